// File: rtl/core_mem_access_unit_pkg.sv
// rtl/core_mem_access_unit_pkg.sv - shared size encodings, state type and lane helpers
package core_mem_access_unit_pkg;

  localparam int WORD_W = 32;

  localparam logic [1:0] MEM_SIZE_B = 2'b00;
  localparam logic [1:0] MEM_SIZE_H = 2'b01;
  localparam logic [1:0] MEM_SIZE_W = 2'b10;
  localparam logic [1:0] MEM_SIZE_X = 2'b11;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_ADDR1,
    ST_DATA1,
    ST_ADDR2,
    ST_DATA2,
    ST_RESP
  } state_e;

  function automatic logic [3:0] size_mask(input logic [1:0] size);
    case (size)
      MEM_SIZE_B: return 4'h1;
      MEM_SIZE_H: return 4'h3;
      default:    return 4'hF;
    endcase
  endfunction

  function automatic logic [2:0] size_bytes(input logic [1:0] size);
    case (size)
      MEM_SIZE_B: return 3'd1;
      MEM_SIZE_H: return 3'd2;
      default:    return 3'd4;
    endcase
  endfunction

endpackage

// File: rtl/core_mem_access_unit_align.sv
// rtl/core_mem_access_unit_align.sv - byte-lane shifter for stores and merge/extend for loads
// Works on a 64-bit two-word window so a split access is just the upper half.
module core_mem_access_unit_align
  import core_mem_access_unit_pkg::*;
(
  input  logic [1:0]          off_i,
  input  logic [1:0]          size_i,
  input  logic                unsigned_i,
  input  logic [WORD_W-1:0]   wdata_i,
  input  logic [WORD_W-1:0]   lo_i,
  input  logic [WORD_W-1:0]   hi_i,
  output logic [7:0]          be64_o,
  output logic [2*WORD_W-1:0] wdata64_o,
  output logic                split_o,
  output logic [WORD_W-1:0]   rdata_o
);

  logic [4:0]        sh_bits;
  logic [WORD_W-1:0] merged;
  logic              sext;

  always_comb begin
    sh_bits   = {off_i, 3'b000};
    be64_o    = {4'b0000, size_mask(size_i)} << off_i;
    wdata64_o = {{WORD_W{1'b0}}, wdata_i} << sh_bits;
    split_o   = ({1'b0, off_i} + size_bytes(size_i)) > 3'd4;
    merged    = WORD_W'({hi_i, lo_i} >> sh_bits);
    sext      = 1'b0;
    case (size_i)
      MEM_SIZE_B: begin
        sext    = ~unsigned_i & merged[7];
        rdata_o = {{24{sext}}, merged[7:0]};
      end
      MEM_SIZE_H: begin
        sext    = ~unsigned_i & merged[15];
        rdata_o = {{16{sext}}, merged[15:0]};
      end
      default: rdata_o = merged;
    endcase
  end

endmodule

// File: rtl/core_mem_access_unit.sv
// rtl/core_mem_access_unit.sv - load/store stage driving a single-outstanding data bus
// Outputs are decoded from the registered state and latched request, so no req->mem path exists.
module core_mem_access_unit
  import core_mem_access_unit_pkg::*;
#(
  parameter int ADDR_W = 32,
  parameter int DATA_W = 32
) (
  input  logic              clk_i,
  input  logic              rst_i,
  input  logic              req_valid_i,
  output logic              req_ready_o,
  input  logic              req_we_i,
  input  logic [1:0]        req_size_i,
  input  logic              req_unsigned_i,
  input  logic [ADDR_W-1:0] req_addr_i,
  input  logic [DATA_W-1:0] req_wdata_i,
  output logic              rsp_valid_o,
  output logic [DATA_W-1:0] rsp_rdata_o,
  output logic              rsp_err_o,
  output logic              stall_o,
  output logic              mem_valid_o,
  input  logic              mem_ready_i,
  output logic              mem_we_o,
  output logic [3:0]        mem_be_o,
  output logic [ADDR_W-1:0] mem_addr_o,
  output logic [DATA_W-1:0] mem_wdata_o,
  input  logic              mem_rvalid_i,
  input  logic [DATA_W-1:0] mem_rdata_i
);

  state_e              state_q;
  logic                we_q;
  logic [1:0]          size_q;
  logic                uns_q;
  logic                err_q;
  logic [ADDR_W-1:0]   addr_q;
  logic [WORD_W-1:0]   wdata_q;
  logic [WORD_W-1:0]   lo_q;
  logic [WORD_W-1:0]   hi_q;

  logic [7:0]          be64;
  logic [2*WORD_W-1:0] wdata64;
  logic                split;
  logic [WORD_W-1:0]   ld_data;
  logic [ADDR_W-1:0]   word_addr;

  core_mem_access_unit_align u_align (
    .off_i      (addr_q[1:0]),
    .size_i     (size_q),
    .unsigned_i (uns_q),
    .wdata_i    (wdata_q),
    .lo_i       (lo_q),
    .hi_i       (hi_q),
    .be64_o     (be64),
    .wdata64_o  (wdata64),
    .split_o    (split),
    .rdata_o    (ld_data)
  );

  assign word_addr = {addr_q[ADDR_W-1:2], 2'b00};

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      state_q <= ST_IDLE;
      we_q    <= 1'b0;
      size_q  <= 2'b00;
      uns_q   <= 1'b0;
      err_q   <= 1'b0;
      addr_q  <= '0;
      wdata_q <= '0;
      lo_q    <= '0;
      hi_q    <= '0;
    end else begin
      case (state_q)
        ST_IDLE: begin
          if (req_valid_i) begin
            we_q    <= req_we_i;
            size_q  <= req_size_i;
            uns_q   <= req_unsigned_i;
            addr_q  <= req_addr_i;
            wdata_q <= req_wdata_i;
            lo_q    <= '0;
            hi_q    <= '0;
            err_q   <= (req_size_i == MEM_SIZE_X);
            state_q <= (req_size_i == MEM_SIZE_X) ? ST_RESP : ST_ADDR1;
          end
        end
        ST_ADDR1: begin
          if (mem_ready_i) begin
            if (!we_q)      state_q <= ST_DATA1;
            else if (split) state_q <= ST_ADDR2;
            else            state_q <= ST_RESP;
          end
        end
        // Read data arriving outside the data states is simply never sampled.
        ST_DATA1: begin
          if (mem_rvalid_i) begin
            lo_q    <= mem_rdata_i;
            state_q <= split ? ST_ADDR2 : ST_RESP;
          end
        end
        ST_ADDR2: begin
          if (mem_ready_i) state_q <= we_q ? ST_RESP : ST_DATA2;
        end
        ST_DATA2: begin
          if (mem_rvalid_i) begin
            hi_q    <= mem_rdata_i;
            state_q <= ST_RESP;
          end
        end
        ST_RESP:  state_q <= ST_IDLE;
        default:  state_q <= ST_IDLE;
      endcase
    end
  end

  always_comb begin
    mem_valid_o = 1'b0;
    mem_we_o    = 1'b0;
    mem_be_o    = 4'h0;
    mem_addr_o  = '0;
    mem_wdata_o = '0;
    case (state_q)
      ST_ADDR1: begin
        mem_valid_o = 1'b1;
        mem_we_o    = we_q;
        mem_be_o    = be64[3:0];
        mem_addr_o  = word_addr;
        mem_wdata_o = wdata64[WORD_W-1:0];
      end
      ST_ADDR2: begin
        mem_valid_o = 1'b1;
        mem_we_o    = we_q;
        mem_be_o    = be64[7:4];
        mem_addr_o  = word_addr + ADDR_W'(4);
        mem_wdata_o = wdata64[2*WORD_W-1:WORD_W];
      end
      default: ;
    endcase
  end

  assign req_ready_o = (state_q == ST_IDLE);
  assign stall_o     = (state_q != ST_IDLE);
  assign rsp_valid_o = (state_q == ST_RESP);
  assign rsp_err_o   = (state_q == ST_RESP) && err_q;
  assign rsp_rdata_o = ((state_q == ST_RESP) && !err_q && !we_q) ? ld_data : '0;

endmodule

// File: tb/tb_core_mem_access_unit.sv
// tb/tb_core_mem_access_unit.sv - directed and random checks against a byte-level access model
module tb_core_mem_access_unit;

  logic        clk_i = 1'b0;
  logic        rst_i;
  logic        req_valid_i, req_ready_o, req_we_i, req_unsigned_i;
  logic [1:0]  req_size_i;
  logic [31:0] req_addr_i, req_wdata_i;
  logic        rsp_valid_o, rsp_err_o, stall_o;
  logic [31:0] rsp_rdata_o;
  logic        mem_valid_o, mem_ready_i, mem_we_o, mem_rvalid_i;
  logic [3:0]  mem_be_o;
  logic [31:0] mem_addr_o, mem_wdata_o, mem_rdata_i;

  core_mem_access_unit dut (
    .clk_i(clk_i), .rst_i(rst_i),
    .req_valid_i(req_valid_i), .req_ready_o(req_ready_o), .req_we_i(req_we_i),
    .req_size_i(req_size_i), .req_unsigned_i(req_unsigned_i), .req_addr_i(req_addr_i),
    .req_wdata_i(req_wdata_i), .rsp_valid_o(rsp_valid_o), .rsp_rdata_o(rsp_rdata_o),
    .rsp_err_o(rsp_err_o), .stall_o(stall_o), .mem_valid_o(mem_valid_o),
    .mem_ready_i(mem_ready_i), .mem_we_o(mem_we_o), .mem_be_o(mem_be_o),
    .mem_addr_o(mem_addr_o), .mem_wdata_o(mem_wdata_o), .mem_rvalid_i(mem_rvalid_i),
    .mem_rdata_i(mem_rdata_i)
  );

  always #5 clk_i = ~clk_i;

  int checks = 0;
  int failures = 0;

  logic [31:0] mem_words [logic [31:0]];
  logic [31:0] obs_addr [0:1];
  logic [3:0]  obs_be [0:1];
  logic        obs_we [0:1];
  logic [31:0] obs_wd [0:1];
  int          nobs;
  logic [31:0] o_rdata;
  logic        o_err;
  int          o_lat;

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  function automatic logic [31:0] word_at(input logic [31:0] wa);
    if (mem_words.exists(wa)) return mem_words[wa];
    return (wa * 32'h9E37_79B1) ^ 32'h5A5A_1234;
  endfunction

  task automatic run_txn(input logic we, input logic [1:0] size, input logic uns,
                         input logic [31:0] addr, input logic [31:0] wdata,
                         input int rwait, input int dwait);
    int nb, nbeats, k, cyc, wcnt, dcnt, nrsp, e_lat;
    logic [31:0] ba, wa, tmpw, raw, e_rdata, pend_addr, h_addr, h_wd, msk;
    logic [31:0] e_addr [0:1];
    logic [3:0]  e_be [0:1];
    logic [31:0] e_wd [0:1];
    logic [3:0]  h_be;
    logic        e_err, pend, stable_ok, stall_ok;

    // Reference: walk the accessed bytes one at a time.
    e_err = (size == 2'b11);
    nb = (size == 2'b00) ? 1 : (size == 2'b01) ? 2 : 4;
    nbeats = 0;
    raw = '0;
    for (int j = 0; j < 2; j++) begin e_addr[j] = '0; e_be[j] = '0; e_wd[j] = '0; end
    if (!e_err) begin
      for (int i = 0; i < nb; i++) begin
        ba = addr + i;
        wa = {ba[31:2], 2'b00};
        k = (wa == {addr[31:2], 2'b00}) ? 0 : 1;
        if (k + 1 > nbeats) nbeats = k + 1;
        e_addr[k] = wa;
        e_be[k][ba[1:0]] = 1'b1;
        e_wd[k][ba[1:0]*8 +: 8] = wdata[i*8 +: 8];
        tmpw = word_at(wa);
        raw[i*8 +: 8] = tmpw[ba[1:0]*8 +: 8];
      end
    end
    e_rdata = '0;
    if (!e_err && !we) begin
      case (size)
        2'b00:   e_rdata = uns ? {24'b0, raw[7:0]} : {{24{raw[7]}}, raw[7:0]};
        2'b01:   e_rdata = uns ? {16'b0, raw[15:0]} : {{16{raw[15]}}, raw[15:0]};
        default: e_rdata = raw;
      endcase
    end
    e_lat = 1 + nbeats * (1 + rwait) + (we ? 0 : nbeats * (1 + dwait));

    @(negedge clk_i);
    chk("req_ready_idle", req_ready_o, 1);
    req_valid_i = 1'b1; req_we_i = we; req_size_i = size; req_unsigned_i = uns;
    req_addr_i = addr; req_wdata_i = wdata;
    @(negedge clk_i);
    req_valid_i = 1'b0; req_we_i = $urandom; req_size_i = $urandom; req_unsigned_i = $urandom;
    req_addr_i = $urandom; req_wdata_i = $urandom;

    cyc = 1; nobs = 0; nrsp = 0; wcnt = 0; dcnt = 0; pend = 0; pend_addr = '0;
    stable_ok = 1; stall_ok = 1; o_lat = -1; o_rdata = '0; o_err = 1'b0;
    h_addr = '0; h_be = '0; h_wd = '0;
    while (cyc < 60 && nrsp == 0) begin
      mem_ready_i = 1'b0; mem_rvalid_i = 1'b0; mem_rdata_i = $urandom;
      if (stall_o !== 1'b1) stall_ok = 0;
      if (rsp_valid_o) begin
        nrsp++; o_lat = cyc; o_rdata = rsp_rdata_o; o_err = rsp_err_o;
      end else if (mem_valid_o) begin
        if (wcnt == 0) begin
          h_addr = mem_addr_o; h_be = mem_be_o; h_wd = mem_wdata_o;
        end else if (mem_addr_o !== h_addr || mem_be_o !== h_be || mem_wdata_o !== h_wd) begin
          stable_ok = 0;
        end
        if (wcnt == rwait) begin
          mem_ready_i = 1'b1;
          if (nobs < 2) begin
            obs_addr[nobs] = mem_addr_o; obs_be[nobs] = mem_be_o;
            obs_we[nobs] = mem_we_o; obs_wd[nobs] = mem_wdata_o;
          end
          nobs++;
          if (!mem_we_o) begin pend = 1; pend_addr = mem_addr_o; dcnt = 0; end
          wcnt = 0;
        end else wcnt++;
      end else if (pend) begin
        if (dcnt == dwait) begin
          mem_rvalid_i = 1'b1; mem_rdata_i = word_at(pend_addr); pend = 0;
        end else dcnt++;
      end
      @(negedge clk_i);
      cyc++;
    end
    mem_ready_i = 1'b0; mem_rvalid_i = 1'b0;

    chk("rsp_count", nrsp, 1);
    chk("rsp_pulse_end", rsp_valid_o, 0);
    chk("ready_after", req_ready_o, 1);
    chk("stall_busy", stall_ok, 1);
    chk("bus_stable", stable_ok, 1);
    chk("beat_count", nobs, nbeats);
    for (int j = 0; j < nbeats && j < nobs; j++) begin
      msk = {{8{e_be[j][3]}}, {8{e_be[j][2]}}, {8{e_be[j][1]}}, {8{e_be[j][0]}}};
      chk($sformatf("beat%0d_addr", j), obs_addr[j], e_addr[j]);
      chk($sformatf("beat%0d_be", j), obs_be[j], e_be[j]);
      chk($sformatf("beat%0d_we", j), obs_we[j], we);
      if (we) chk($sformatf("beat%0d_wdata", j), obs_wd[j] & msk, e_wd[j]);
    end
    chk("rsp_err", o_err, e_err);
    chk("rsp_rdata", o_rdata, e_rdata);
    chk("rsp_latency", o_lat, e_lat);
  endtask

  logic [31:0] h_addr0;
  logic [3:0]  h_be0;
  logic [31:0] r;

  initial begin
    rst_i = 1'b1; req_valid_i = 1'b0; req_we_i = 1'b0; req_size_i = 2'b00;
    req_unsigned_i = 1'b0; req_addr_i = '0; req_wdata_i = '0;
    mem_ready_i = 1'b0; mem_rvalid_i = 1'b0; mem_rdata_i = '0;
    mem_words[32'h0000_0200] = 32'h80AA_BBCC;
    mem_words[32'h0000_0104] = 32'h3333_1111;
    mem_words[32'h0000_0108] = 32'h2222_5555;

    @(negedge clk_i); @(negedge clk_i);
    chk("rst_req_ready", req_ready_o, 1);
    chk("rst_stall", stall_o, 0);
    chk("rst_rsp_valid", rsp_valid_o, 0);
    chk("rst_rsp_err", rsp_err_o, 0);
    chk("rst_rsp_rdata", rsp_rdata_o, 0);
    chk("rst_mem_valid", mem_valid_o, 0);
    chk("rst_mem_we", mem_we_o, 0);
    chk("rst_mem_be", mem_be_o, 0);
    chk("rst_mem_addr", mem_addr_o, 0);
    chk("rst_mem_wdata", mem_wdata_o, 0);
    rst_i = 1'b0;

    run_txn(1'b1, 2'b10, 1'b0, 32'h0000_0100, 32'hDEAD_BEEF, 0, 0);
    chk("st_word_wdata", obs_wd[0], 32'hDEAD_BEEF);
    chk("st_word_lat", o_lat, 2);

    run_txn(1'b0, 2'b00, 1'b0, 32'h0000_0203, 32'h0, 0, 0);
    chk("lb_be", obs_be[0], 4'h8);
    chk("lb_addr", obs_addr[0], 32'h200);
    chk("lb_rdata", o_rdata, 32'hFFFF_FF80);
    chk("lb_lat", o_lat, 3);
    run_txn(1'b0, 2'b00, 1'b1, 32'h0000_0203, 32'h0, 0, 0);
    chk("lbu_rdata", o_rdata, 32'h0000_0080);

    run_txn(1'b0, 2'b10, 1'b0, 32'h0000_0106, 32'h0, 0, 0);
    chk("split_ld_a0", obs_addr[0], 32'h104);
    chk("split_ld_be0", obs_be[0], 4'hC);
    chk("split_ld_a1", obs_addr[1], 32'h108);
    chk("split_ld_be1", obs_be[1], 4'h3);
    chk("split_ld_rdata", o_rdata, 32'h5555_3333);
    chk("split_ld_lat", o_lat, 5);

    run_txn(1'b1, 2'b01, 1'b0, 32'hFFFF_FFFF, 32'h0000_ABCD, 0, 0);
    chk("split_st_a0", obs_addr[0], 32'hFFFF_FFFC);
    chk("split_st_wd0", obs_wd[0], 32'hCD00_0000);
    chk("split_st_a1", obs_addr[1], 32'h0000_0000);
    chk("split_st_wd1", obs_wd[1], 32'h0000_00AB);
    chk("split_st_lat", o_lat, 3);

    run_txn(1'b0, 2'b11, 1'b0, 32'h0000_0040, 32'h0, 0, 0);
    chk("illegal_nobus", nobs, 0);
    chk("illegal_err", o_err, 1);
    chk("illegal_rdata", o_rdata, 0);
    chk("illegal_lat", o_lat, 1);

    // Bus back-pressure, then reset while waiting for read data.
    @(negedge clk_i);
    req_valid_i = 1'b1; req_we_i = 1'b0; req_size_i = 2'b10; req_unsigned_i = 1'b0;
    req_addr_i = 32'h0000_0300;
    @(negedge clk_i);
    req_valid_i = 1'b0; req_addr_i = 32'h0000_0ABC;
    chk("bp_valid", mem_valid_o, 1);
    chk("bp_addr", mem_addr_o, 32'h300);
    chk("bp_be", mem_be_o, 4'hF);
    h_addr0 = mem_addr_o; h_be0 = mem_be_o;
    for (int i = 0; i < 3; i++) begin
      @(negedge clk_i);
      chk("bp_hold_valid", mem_valid_o, 1);
      chk("bp_hold_addr", mem_addr_o, h_addr0);
      chk("bp_hold_be", mem_be_o, h_be0);
    end
    mem_ready_i = 1'b1;
    @(negedge clk_i);
    mem_ready_i = 1'b0;
    chk("bp_data1_novalid", mem_valid_o, 0);
    chk("bp_data1_stall", stall_o, 1);
    rst_i = 1'b1;
    @(negedge clk_i);
    rst_i = 1'b0;
    chk("rst_mid_ready", req_ready_o, 1);
    chk("rst_mid_stall", stall_o, 0);
    chk("rst_mid_rsp", rsp_valid_o, 0);
    mem_rvalid_i = 1'b1; mem_rdata_i = 32'h1234_5678;
    for (int i = 0; i < 3; i++) begin
      @(negedge clk_i);
      mem_rvalid_i = 1'b0;
      chk("late_rvalid_rsp", rsp_valid_o, 0);
      chk("late_rvalid_idle", req_ready_o, 1);
    end

    for (int t = 0; t < 40; t++) begin
      r = $urandom;
      run_txn(r[0], (r[7:5] == 3'd0) ? 2'b11 : 2'(r[4:2] % 3), r[1],
              (t % 5 == 0) ? (32'hFFFF_FFFC | 32'($urandom_range(0, 3))) : $urandom,
              $urandom, $urandom_range(0, 2), $urandom_range(0, 2));
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
